gray_counter: RTL and testbench

Registered Gray-code counter that produces the stepping Gray sequence consumed by the `gray_code` conversion and pointer logic downstream. It keeps a binary count internally and drives a registered, glitch-free Gray output that changes by exactly one bit per step. It also provides up/down counting, a parallel load given in Gray form, and a wrap pulse. It is the source stage for FIFO pointers and position encoders in the design.

---
 rtl/gray_pkg.sv | 22 ++
 rtl/gray_to_bin.sv | 14 +
 rtl/gray_counter.sv | 73 +++++++
 tb/tb_gray_counter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers for the counter and downstream pointer logic.
// Functions work on a 32-bit container; callers cast to and from their own width.
package gray_pkg;

  localparam int unsigned DEFAULT_GRAY_WIDTH = 4;
  localparam int unsigned GRAY_MAX_WIDTH     = 32;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended upper bits leave the prefix XOR unchanged, so any width <= 32 works.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray);
    logic [GRAY_MAX_WIDTH-1:0] bin;
    bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all
// Gray bits at and above its position.
module gray_to_bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_value,
  output logic [WIDTH-1:0] binary_value
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign binary_value[i] = ^gray_value[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down counter with a registered Gray output, Gray-form parallel load and a
// registered wrap pulse. Gray and binary state are kept in separate flops.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_GRAY_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_value,
  output logic [WIDTH-1:0] binary_value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_bin_d;
  logic [WIDTH-1:0] w_gray_d;
  logic             w_wrap_d;

  gray_to_bin #(
    .WIDTH(WIDTH)
  ) u_load_conv (
    .gray_value  (load_gray),
    .binary_value(w_load_bin)
  );

  // Load takes priority over stepping; the loaded Gray word is registered as given.
  always_comb begin
    w_bin_d  = r_bin;
    w_gray_d = r_gray;
    w_wrap_d = 1'b0;
    if (load) begin
      w_bin_d  = w_load_bin;
      w_gray_d = load_gray;
    end else if (en) begin
      if (up) begin
        w_bin_d  = r_bin + ONE;
        w_wrap_d = &r_bin;
      end else begin
        w_bin_d  = r_bin - ONE;
        w_wrap_d = ~|r_bin;
      end
      w_gray_d = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(w_bin_d)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_d;
      r_gray <= w_gray_d;
      r_wrap <= w_wrap_d;
    end
  end

  assign gray_value   = r_gray;
  assign binary_value = r_bin;
  assign wrap         = r_wrap;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter at WIDTH = 4; compares {binary, gray, wrap}
// against hand-computed vectors.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_gray;
  logic [3:0] gray_value;
  logic [3:0] binary_value;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] GSEQ [17] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
    4'b0000
  };

  gray_counter #(
    .WIDTH(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .up          (up),
    .load        (load),
    .load_gray   (load_gray),
    .gray_value  (gray_value),
    .binary_value(binary_value),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_gray = 4'b0000;
    #3;
    checks++;
    if ({binary_value, gray_value, wrap} !== 9'b0000_0000_0) begin
      errors++;
      $display("FAIL reset_initial got %b want 000000000", {binary_value, gray_value, wrap});
    end
    tick(); tick();
    rst_n = 1'b1;
    en = 1'b1;
    repeat (6) tick();
    en = 1'b0;
    checks++;
    if ({binary_value, gray_value, wrap} !== {4'd6, 4'b0101, 1'b0}) begin
      errors++;
      $display("FAIL reset_precount got %b want 011001010", {binary_value, gray_value, wrap});
    end
    en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({binary_value, gray_value, wrap} !== 9'b0000_0000_0) begin
      errors++;
      $display("FAIL reset_async got %b want 000000000", {binary_value, gray_value, wrap});
    end
    tick(); tick();
    checks++;
    if ({binary_value, gray_value, wrap} !== 9'b0000_0000_0) begin
      errors++;
      $display("FAIL reset_held got %b want 000000000", {binary_value, gray_value, wrap});
    end
    en = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({binary_value, gray_value, wrap} !== 9'b0000_0000_0) begin
      errors++;
      $display("FAIL reset_release got %b want 000000000", {binary_value, gray_value, wrap});
    end
  endtask

  task automatic test_count_up();
    logic [3:0] prev;
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      prev = gray_value;
      tick();
      checks++;
      if ({binary_value, gray_value, wrap} !== {4'(i), GSEQ[i], (i == 16)}) begin
        errors++;
        $display("FAIL count_up step %0d got %b want %b", i,
                 {binary_value, gray_value, wrap}, {4'(i), GSEQ[i], (i == 16)});
      end
      checks++;
      if ($countones(prev ^ gray_value) != 1) begin
        errors++;
        $display("FAIL count_up_onebit step %0d got %b->%b want one bit change", i,
                 prev, gray_value);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_count_down();
    en = 1'b1; up = 1'b0;
    tick();
    checks++;
    if ({binary_value, gray_value, wrap} !== {4'd15, 4'b1000, 1'b1}) begin
      errors++;
      $display("FAIL count_down_wrap got %b want 111110001", {binary_value, gray_value, wrap});
    end
    tick();
    checks++;
    if ({binary_value, gray_value, wrap} !== {4'd14, 4'b1001, 1'b0}) begin
      errors++;
      $display("FAIL count_down_next got %b want 111010010", {binary_value, gray_value, wrap});
    end
    en = 1'b0;
  endtask

  task automatic test_load();
    load = 1'b1; load_gray = 4'b1100;
    tick();
    load = 1'b0;
    checks++;
    if ({binary_value, gray_value, wrap} !== {4'd8, 4'b1100, 1'b0}) begin
      errors++;
      $display("FAIL load got %b want 100011000", {binary_value, gray_value, wrap});
    end
    en = 1'b1; up = 1'b1;
    tick();
    en = 1'b0;
    checks++;
    if ({binary_value, gray_value, wrap} !== {4'd9, 4'b1101, 1'b0}) begin
      errors++;
      $display("FAIL load_then_up got %b want 100111010", {binary_value, gray_value, wrap});
    end
  endtask

  task automatic test_load_and_en();
    load = 1'b1; load_gray = 4'b1000;
    tick();
    checks++;
    if ({binary_value, gray_value, wrap} !== {4'd15, 4'b1000, 1'b0}) begin
      errors++;
      $display("FAIL load_to_max got %b want 111110000", {binary_value, gray_value, wrap});
    end
    load_gray = 4'b0111; en = 1'b1; up = 1'b1;
    tick();
    load = 1'b0; en = 1'b0;
    checks++;
    if ({binary_value, gray_value, wrap} !== {4'd5, 4'b0111, 1'b0}) begin
      errors++;
      $display("FAIL load_beats_en got %b want 010101110", {binary_value, gray_value, wrap});
    end
  endtask

  task automatic test_hold_reversal();
    logic [3:0] prev;
    logic [3:0] exp_g;
    logic [3:0] exp_b;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({binary_value, gray_value, wrap} !== {4'd5, 4'b0111, 1'b0}) begin
        errors++;
        $display("FAIL hold cycle %0d got %b want 010101110", i,
                 {binary_value, gray_value, wrap});
      end
    end
    load = 1'b1; load_gray = 4'b0010;
    tick();
    load = 1'b0;
    checks++;
    if ({binary_value, gray_value, wrap} !== {4'd3, 4'b0010, 1'b0}) begin
      errors++;
      $display("FAIL load_three got %b want 001100100", {binary_value, gray_value, wrap});
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up = (i % 2 == 0);
      exp_g = up ? 4'b0110 : 4'b0010;
      exp_b = up ? 4'd4 : 4'd3;
      prev = gray_value;
      tick();
      checks++;
      if ({binary_value, gray_value, wrap} !== {exp_b, exp_g, 1'b0}) begin
        errors++;
        $display("FAIL reversal step %0d got %b want %b", i,
                 {binary_value, gray_value, wrap}, {exp_b, exp_g, 1'b0});
      end
      checks++;
      if ($countones(prev ^ gray_value) != 1) begin
        errors++;
        $display("FAIL reversal_onebit step %0d got %b->%b want one bit change", i,
                 prev, gray_value);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_load_and_en();
    test_hold_reversal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
